// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (4-7).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        legal, sgn, sa, sb, is_div, dz;
    logic [4:0]  cyc;
    logic [63:0] ext_a, ext_b, prod, res;
    logic [31:0] ua, ub, q, r, quo, rem;
    always_comb begin
`ifdef MDU_MADD_EN
        legal = 1'b1;
`else
        legal = !op[2];
`endif
        cyc    = (op[1] && !op[2]) ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
        sgn    = !op_q[0];
        is_div = op_q[2:1] == 2'b01;
        dz     = is_div && b_q == 32'd0;
        ext_a  = {{32{sgn & a_q[31]}}, a_q};
        ext_b  = {{32{sgn & b_q[31]}}, b_q};
        prod   = ext_a * ext_b;
        // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
        sa     = sgn & a_q[31];
        sb     = sgn & b_q[31];
        ua     = sa ? -a_q : a_q;
        ub     = sb ? -b_q : b_q;
        q      = ub == 32'd0 ? 32'd0 : ua / ub;
        r      = ub == 32'd0 ? 32'd0 : ua % ub;
        quo    = (sa ^ sb) ? -q : q;
        rem    = sa ? -r : r;
`ifdef MDU_MADD_EN
        res    = op_q[2] ? (op_q[1] ? {hi, lo} - prod : {hi, lo} + prod) :
                 op_q[1] ? {rem, quo} : prod;
`else
        res    = op_q[1] ? {rem, quo} : prod;
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 5'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (state == IDLE) begin
            if (start && legal) begin
                state <= RUN;
                busy  <= 1'b1;
                cnt   <= cyc;
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
            end else if (!start) begin
                if (wr_hi) hi <= wdata;
                if (wr_lo) lo <= wdata;
            end
        end else begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (!dz) {hi, lo} <= res;
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu (default build or MDU_MADD_EN).
module tb_mdu;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;
    int          errors = 0, checks = 0, n;

    mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
             .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic write(input logic h, input logic l, input logic [31:0] d);
        wr_hi = h; wr_lo = l; wdata = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        launch(3'd0, 32'hFFFFFFFD, 32'd5);
        wait_busy(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        launch(3'd3, 32'd100, 32'd7);
        wait_busy(n);
        chk("divu_cycles", n, 32'd10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        launch(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_busy(n);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);

        launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(n);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'd0);

        write(1'b1, 1'b0, 32'h11);
        write(1'b0, 1'b1, 32'h22);
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);
        launch(3'd2, 32'd5, 32'd0);
        wait_busy(n);
        chk("dz_cycles", n, 32'd10);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // Collision: start and MTLO pulsed while a MULT is running.
        launch(3'd0, 32'd6, 32'd7);
        chk("col_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        chk("col_lo_hidden", lo, 32'h22);
        wait_busy(n);
        chk("col_remaining", n, 32'd3);
        chk("col_lo", lo, 32'd42);
        chk("col_hi", hi, 32'd0);
        repeat (3) @(negedge clk);
        chk("col_no_restart", {31'd0, busy}, 32'd0);
        chk("col_lo_kept", lo, 32'd42);

        // start and MTHI in the same idle cycle: start wins.
        wr_hi = 1'b1; wdata = 32'hBEEF;
        launch(3'd1, 32'hFFFFFFFF, 32'd2);
        wr_hi = 1'b0;
        chk("sw_hi_hold", hi, 32'd0);
        wait_busy(n);
        chk("sw_cycles", n, 32'd5);
        chk("sw_hi", hi, 32'd1);
        chk("sw_lo", lo, 32'hFFFFFFFE);

        launch(3'd2, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_lo", lo, 32'd0);

        write(1'b0, 1'b1, 32'hFFFFFFFF);
        launch(3'd5, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_busy(n);
        chk("maddu_cycles", n, 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
        launch(3'd6, 32'd2, 32'hFFFFFFFF);
        wait_busy(n);
        chk("msub_hi", hi, 32'd1);
        chk("msub_lo", lo, 32'd2);
`else
        chk("maddu_off_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("maddu_off_busy_late", {31'd0, busy}, 32'd0);
        chk("maddu_off_hi", hi, 32'd0);
        chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS core. It sits beside the EX stage and executes MULT/MULTU/DIV/DIVU into the architectural HI/LO pair over a fixed multi-cycle latency. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. `busy` is driven to the hazard unit, which stalls any HI/LO-touching instruction in ID while `start | busy`.

## Interface
- `MULT_CYCLES`, default 5: busy duration for multiply-class ops (legal range 1–31).
- `DIV_CYCLES`, default 10: busy duration for divide ops (legal range 1–31).

- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: launch the op selected by `op`; sampled on the rising edge.
- `op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `a` input 32: rs operand.
- `b` input 32: rt operand.
- `wr_hi` input 1: write `wdata` into HI (MTHI).
- `wr_lo` input 1: write `wdata` into LO (MTLO).
- `wdata` input 32: MTHI/MTLO data.
- `busy` output 1: an operation is in flight.
- `hi` output 32: registered HI, for MFHI.
- `lo` output 32: registered LO, for MFLO.

## Operation
- Two states:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1; a 5-bit down-counter is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
- IDLE with `start` = 1 and a legal op:
  - Latch `op`, `a`, `b`, and the current HI/LO.
  - Load the counter and enter RUN.
- RUN:
  - Decrement the counter each edge.
  - On the edge where the counter reaches 0, write the result to HI/LO and return to IDLE.
- Results:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (b == 0):
  - The full busy period still elapses.
  - HI/LO are left unchanged.
- `wr_hi`/`wr_lo`:
  - Honoured only in IDLE with `start` = 0; they take effect at the next edge.
  - Both may be asserted together.
- Ignored inputs:
  - `start` asserted in RUN is ignored.
  - `wr_hi`/`wr_lo` asserted in RUN are ignored.
  - When `start` and `wr_*` coincide in IDLE, `start` wins and the write is dropped.
- `hi`/`lo` are always the registered architectural values; no intermediate results are visible.
- Reset, asynchronous and valid at any time, including mid-operation:
  - `busy` = 0, `hi` = 0, `lo` = 0, counter = 0, state = IDLE.
  - Any in-flight op is discarded.

## Timing
- `start` sampled at edge T: `busy` is 1 from just after T until just after T+N, where N = cycle count. That is exactly N cycles high.
- HI/LO update at edge T+N; `busy` falls at the same edge.
- Back-to-back ops: a new `start` is accepted at edge T+N+1 at the earliest, with HI/LO from the previous op already visible.
- MTHI/MTLO: `hi`/`lo` reflect `wdata` one edge after the write is sampled.
- `busy`, `hi` and `lo` are purely registered outputs, with no combinational path from inputs.

## Configuration
- Macro: `MDU_MADD_EN`.
- Defined: ops 4–7 are legal and use `MULT_CYCLES`.
  - MADD/MADDU: {HI,LO} = {HI,LO} at start + product.
  - MSUB/MSUBU: {HI,LO} = {HI,LO} at start − product.
  - Accumulation is modulo 2^64; signedness follows the op.
- Undefined:
  - `start` with op 4–7 is ignored: no busy, HI/LO unchanged.
  - The accumulate datapath is absent.

## Test plan
- MULT: `a` = 0xFFFFFFFD (−3), `b` = 5 → `busy` high 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIVU: `a` = 100, `b` = 7 → `busy` high 10 cycles, then LO = 14, HI = 2. DIV `a` = −7, `b` = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Divide by zero: MTHI 0x11, MTLO 0x22, then DIV `b` = 0 → `busy` high 10 cycles, HI = 0x11, LO = 0x22 after.
- Collisions:
  - During MULT busy, pulse `start` (DIVU) and `wr_lo` (0xDEAD) → both ignored; MULT result lands at T+5 and `busy` stays 0 afterwards.
  - In IDLE, `start` + `wr_hi` together → `start` wins and HI holds the op result, not `wdata`.
- Reset mid-op: assert `reset` 4 cycles into DIV → `busy`, `hi` and `lo` go 0 immediately without waiting for a clock edge; no later update occurs.
- With `MDU_MADD_EN`: HI = 0, LO = 0xFFFFFFFF, MADDU `a` = 1, `b` = 1 → HI = 1, LO = 0 after 5 cycles. Without the macro, the same stimulus leaves `busy` at 0 and HI/LO unchanged.
